comparator_sweep_driver: RTL and testbench

// - Stimulus side of the switch-bus/LED comparator interface: drives the 2*OP_W-bit operand bus a

---
 rtl/comparator_sweep_if.sv | 32 +++
 rtl/comparator_sweep_driver.sv | 127 ++++++++++++
 tb/tb_comparator_sweep_driver.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/comparator_sweep_if.sv
// Switch-bus / LED comparator self-test bus.
// master: the sweep driver (drives the operand bus and the result status).
// slave : whatever sits on the other side (issues start, returns the LED).
//
// Handshake: start is a level qualifier, not a valid/ready pair. It is acted
// on at a rising clk edge only while the driver is idle or done (busy==0).
// While busy==1 start is ignored. led_in must be a combinational function of
// sw_out. It is sampled once per vector after sw_out has been stable for the
// settle time.
interface comparator_sweep_if #(
  parameter int OP_W = 4
);
  logic              start;
  logic              led_in;
  logic [2*OP_W-1:0] sw_out;
  logic              busy;
  logic              done;
  logic              pass;
  logic [2*OP_W:0]   err_count;
  logic              fail_valid;
  logic [2*OP_W-1:0] first_fail;

  modport master (
    input  start, led_in,
    output sw_out, busy, done, pass, err_count, fail_valid, first_fail
  );

  modport slave (
    output start, led_in,
    input  sw_out, busy, done, pass, err_count, fail_valid, first_fail
  );
endinterface

// File: rtl/comparator_sweep_driver.sv
// Exhaustive self-test sweep for a greater-than comparator.
// The driver walks every {A,B} operand pair on sw_out. It checks led_in
// against A>B after a settle delay, counts mismatches and captures the first
// failing vector.
// Optional build macro: STOP_ON_FAIL_EN. When defined, the first mismatch
// ends the sweep immediately.
module comparator_sweep_driver #(
  parameter int OP_W          = 4,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  n_rst,
  comparator_sweep_if.master    bus,
  output logic [1:0]            dbg_state
);

  localparam int VW    = 2 * OP_W;
  localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [VW-1:0]    sw_q, sw_d;
  logic [VW:0]      err_q, err_d;
  logic             fv_q, fv_d;
  logic [VW-1:0]    ff_q, ff_d;

  logic [OP_W-1:0]  op_a;
  logic [OP_W-1:0]  op_b;
  logic             mismatch;
  logic             stop_hit;

  assign op_a     = sw_q[VW-1:OP_W];
  assign op_b     = sw_q[OP_W-1:0];
  assign mismatch = (bus.led_in != (op_a > op_b));

`ifdef STOP_ON_FAIL_EN
  assign stop_hit = mismatch;
`else
  assign stop_hit = 1'b0;
`endif

  // Register all sweep state; reset aborts any sweep and clears results.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      sw_q    <= '0;
      err_q   <= '0;
      fv_q    <= 1'b0;
      ff_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sw_q    <= sw_d;
      err_q   <= err_d;
      fv_q    <= fv_d;
      ff_q    <= ff_d;
    end
  end

  // Next-state logic: start, settle wait, per-vector sample and advance.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sw_d    = sw_q;
    err_d   = err_q;
    fv_d    = fv_q;
    ff_d    = ff_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (bus.start) begin
          sw_d    = '0;
          err_d   = '0;
          fv_d    = 1'b0;
          ff_d    = '0;
          cnt_d   = '0;
          state_d = (SETTLE_CYCLES == 0) ? ST_SAMPLE : ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (cnt_q == CNT_LAST) begin
          state_d = ST_SAMPLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_SAMPLE: begin
        if (mismatch) begin
          if (err_q != '1) begin
            err_d = err_q + (VW+1)'(1);
          end
          if (!fv_q) begin
            ff_d = sw_q;
            fv_d = 1'b1;
          end
        end
        cnt_d = '0;
        // The all-ones vector is the last one; sw_out never wraps.
        if (stop_hit || (sw_q == '1)) begin
          state_d = ST_DONE;
        end else begin
          sw_d    = sw_q + VW'(1);
          state_d = (SETTLE_CYCLES == 0) ? ST_SAMPLE : ST_SETTLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.sw_out     = sw_q;
  assign bus.busy       = (state_q == ST_SETTLE) || (state_q == ST_SAMPLE);
  assign bus.done       = (state_q == ST_DONE);
  assign bus.pass       = (state_q == ST_DONE) && (err_q == '0);
  assign bus.err_count  = err_q;
  assign bus.fail_valid = fv_q;
  assign bus.first_fail = ff_q;
  assign dbg_state      = state_q;

endmodule

// File: tb/tb_comparator_sweep_driver.sv
// Directed bench for comparator_sweep_driver (OP_W=4). dut0 uses
// SETTLE_CYCLES=2 and dut1 uses SETTLE_CYCLES=0. Each has its own comparator
// model on led_in.
module tb_comparator_sweep_driver;

  logic clk = 1'b0;
  logic n_rst = 1'b0;
  int   model0 = 0;
  int   model1 = 0;
  int   n_cmp = 0;
  int   n_fail = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  comparator_sweep_if #(.OP_W(4)) if0 ();
  comparator_sweep_if #(.OP_W(4)) if1 ();
  logic [1:0] dbg0, dbg1;

  comparator_sweep_driver #(.OP_W(4), .SETTLE_CYCLES(2)) dut0 (
    .clk(clk), .n_rst(n_rst), .bus(if0.master), .dbg_state(dbg0));
  comparator_sweep_driver #(.OP_W(4), .SETTLE_CYCLES(0)) dut1 (
    .clk(clk), .n_rst(n_rst), .bus(if1.master), .dbg_state(dbg1));

  // Comparator models: 0 ideal, 1 inverted, 2 stuck-0, 3 stuck-1,
  // 4 ideal except inverted at vector 8'h5A.
  function automatic logic led_model(input int m, input logic [7:0] sw);
    logic gt;
    gt = (sw[7:4] > sw[3:0]);
    case (m)
      1:       return ~gt;
      2:       return 1'b0;
      3:       return 1'b1;
      4:       return (sw == 8'h5A) ? ~gt : gt;
      default: return gt;
    endcase
  endfunction

  assign if0.led_in = led_model(model0, if0.sw_out);
  assign if1.led_in = led_model(model1, if1.sw_out);

  typedef struct {
    int         model;
    int         exp_err;
    logic [7:0] exp_first;
    logic       exp_fv;
    logic       exp_pass;
    int         exp_cycles;
    logic [7:0] exp_sw;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait for done on the selected DUT; returns edges counted.
  task automatic wait_done(input int which, input int bound, output int cycles);
    cycles = 0;
    while (cycles < bound) begin
      tick();
      cycles++;
      if ((which == 0 && if0.done) || (which == 1 && if1.done)) return;
    end
    n_cmp++;
    n_fail++;
    $display("FAIL wait_done%0d: timeout after %0d cycles", which, bound);
  endtask

  task automatic chk_zero0(input string tag);
    chk({tag, " busy"}, {31'd0, if0.busy}, 0);
    chk({tag, " done"}, {31'd0, if0.done}, 0);
    chk({tag, " pass"}, {31'd0, if0.pass}, 0);
    chk({tag, " err"}, {23'd0, if0.err_count}, 0);
    chk({tag, " fv"}, {31'd0, if0.fail_valid}, 0);
    chk({tag, " ff"}, {24'd0, if0.first_fail}, 0);
    chk({tag, " sw"}, {24'd0, if0.sw_out}, 0);
    chk({tag, " state"}, {30'd0, dbg0}, 0);
  endtask

  initial begin
    int cyc;
    if0.start = 1'b0;
    if1.start = 1'b0;

    vecs[0] = '{0, 0,   8'h00, 1'b0, 1'b1, 768, 8'hFF};
`ifdef STOP_ON_FAIL_EN
    vecs[1] = '{1, 1,   8'h00, 1'b1, 1'b0, 3,   8'h00};
    vecs[2] = '{2, 1,   8'h10, 1'b1, 1'b0, 51,  8'h10};
    vecs[3] = '{3, 1,   8'h00, 1'b1, 1'b0, 3,   8'h00};
    vecs[4] = '{4, 1,   8'h5A, 1'b1, 1'b0, 273, 8'h5A};
`else
    vecs[1] = '{1, 256, 8'h00, 1'b1, 1'b0, 768, 8'hFF};
    vecs[2] = '{2, 120, 8'h10, 1'b1, 1'b0, 768, 8'hFF};
    vecs[3] = '{3, 136, 8'h00, 1'b1, 1'b0, 768, 8'hFF};
    vecs[4] = '{4, 1,   8'h5A, 1'b1, 1'b0, 768, 8'hFF};
`endif

    // Reset
    repeat (3) tick();
    chk_zero0("reset");
    chk("reset dut1 busy", {31'd0, if1.busy}, 0);
    chk("reset dut1 done", {31'd0, if1.done}, 0);
    n_rst = 1'b1;
    tick();

    // Table-driven sweeps on dut0
    for (int i = 0; i < 5; i++) begin
      model0 = vecs[i].model;
      if0.start = 1'b1;
      tick();
      if0.start = 1'b0;
      chk($sformatf("v%0d start busy", i), {31'd0, if0.busy}, 1);
      chk($sformatf("v%0d start done", i), {31'd0, if0.done}, 0);
      chk($sformatf("v%0d start err", i), {23'd0, if0.err_count}, 0);
      chk($sformatf("v%0d start sw", i), {24'd0, if0.sw_out}, 0);
      wait_done(0, 2000, cyc);
      chk($sformatf("v%0d cycles", i), cyc, vecs[i].exp_cycles);
      chk($sformatf("v%0d err", i), {23'd0, if0.err_count}, vecs[i].exp_err);
      chk($sformatf("v%0d first", i), {24'd0, if0.first_fail}, {24'd0, vecs[i].exp_first});
      chk($sformatf("v%0d fv", i), {31'd0, if0.fail_valid}, {31'd0, vecs[i].exp_fv});
      chk($sformatf("v%0d pass", i), {31'd0, if0.pass}, {31'd0, vecs[i].exp_pass});
      chk($sformatf("v%0d sw", i), {24'd0, if0.sw_out}, {24'd0, vecs[i].exp_sw});
      repeat (2) tick();
      chk($sformatf("v%0d hold done", i), {31'd0, if0.done}, 1);
      chk($sformatf("v%0d hold err", i), {23'd0, if0.err_count}, vecs[i].exp_err);
    end

    // Reset mid-sweep at sw_out = 8'h80
    model0 = 0;
    if0.start = 1'b1;
    tick();
    if0.start = 1'b0;
    cyc = 0;
    while (if0.sw_out != 8'h80 && cyc < 1000) begin
      tick();
      cyc++;
    end
    chk("mid reach 80", cyc, 384);
    n_rst = 1'b0;
    tick();
    chk_zero0("midreset");
    n_rst = 1'b1;
    tick();
    chk("post reset idle", {30'd0, dbg0}, 0);

    // Start pulse while busy must not disturb the sw_out sequence
    if0.start = 1'b1;
    tick();
    if0.start = 1'b0;
    for (int k = 1; k <= 300; k++) exp_q.push_back(8'(k / 3));
    for (int k = 1; k <= 300; k++) begin
      if0.start = (k == 100);
      tick();
      chk($sformatf("busy sw k%0d", k), {24'd0, if0.sw_out}, {24'd0, exp_q.pop_front()});
    end
    if0.start = 1'b0;
    wait_done(0, 2000, cyc);
    chk("busy start cycles", cyc, 468);
    chk("busy start pass", {31'd0, if0.pass}, 1);

    // dut1: zero settle, start held high across DONE
    model1 = 0;
    if1.start = 1'b1;
    tick();
    chk("z start busy", {31'd0, if1.busy}, 1);
    wait_done(1, 1000, cyc);
    chk("z cycles", cyc, 256);
    chk("z pass", {31'd0, if1.pass}, 1);
    chk("z err", {23'd0, if1.err_count}, 0);
    chk("z sw", {24'd0, if1.sw_out}, 8'hFF);
    tick();
    if1.start = 1'b0;
    chk("z restart busy", {31'd0, if1.busy}, 1);
    chk("z restart done", {31'd0, if1.done}, 0);
    chk("z restart sw", {24'd0, if1.sw_out}, 0);
    wait_done(1, 1000, cyc);
    chk("z second cycles", cyc, 256);
    chk("z second pass", {31'd0, if1.pass}, 1);

    // dut1: start from DONE clears prior failure results
    model1 = 2;
    if1.start = 1'b1;
    tick();
    if1.start = 1'b0;
    wait_done(1, 1000, cyc);
    chk("z st0 fv", {31'd0, if1.fail_valid}, 1);
    chk("z st0 first", {24'd0, if1.first_fail}, 8'h10);
    model1 = 0;
    if1.start = 1'b1;
    tick();
    if1.start = 1'b0;
    chk("z clr err", {23'd0, if1.err_count}, 0);
    chk("z clr fv", {31'd0, if1.fail_valid}, 0);
    chk("z clr ff", {24'd0, if1.first_fail}, 0);
    wait_done(1, 1000, cyc);
    chk("z clr pass", {31'd0, if1.pass}, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
